// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the registered round-robin priority encoder.
package prio_enc_pkg;

  typedef enum logic {PE_FIXED = 1'b0, PE_RR = 1'b1} pe_mode_t;

  // Index of the highest set bit, or -1 when the vector is all-zero.
  function automatic int msb_index(input logic [31:0] vec);
    int idx;
    idx = -1;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational MSB-first search: index of the highest set bit and a found flag.
module prio_find #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Ascending scan: the last hit overwrites earlier ones, so the MSB wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed or round-robin arbitration per transaction
// and a valid/ready handshake on both sides.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_none
);

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [WIDTH-1:0] out_onehot_q, out_onehot_d;
  logic             out_none_q, out_none_d;
  logic [IDX_W:0]   ptr_q, ptr_d;

  logic [WIDTH-1:0] rr_mask;
  logic [WIDTH-1:0] masked_vec;
  logic [IDX_W-1:0] masked_idx, full_idx, win_idx;
  logic             masked_found, full_found;
  logic             accept;
  logic             mode_rr;

  // ptr==WIDTH keeps every bit; ptr==0 keeps none, forcing the MSB fallback.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rr_mask[i] = ((IDX_W+1)'(i) < ptr_q);
    end
  end

  assign masked_vec = in_vec & rr_mask;
  assign mode_rr    = (pe_mode_t'(in_mode) == PE_RR);

  prio_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_find_masked (
    .vec   (masked_vec),
    .idx   (masked_idx),
    .found (masked_found)
  );

  prio_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_find_full (
    .vec   (in_vec),
    .idx   (full_idx),
    .found (full_found)
  );

  assign win_idx  = (mode_rr && masked_found) ? masked_idx : full_idx;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    out_none_d   = out_none_q;
    ptr_d        = ptr_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_none_d   = !full_found;
      out_idx_d    = full_found ? win_idx : '0;
      out_onehot_d = full_found ? (WIDTH'(1) << win_idx) : '0;
      if (mode_rr && full_found) ptr_d = {1'b0, win_idx};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Result/pointer stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      out_none_q   <= 1'b0;
      ptr_q        <= (IDX_W+1)'(WIDTH);
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      out_none_q   <= out_none_d;
      ptr_q        <= ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign out_none   = out_none_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr (WIDTH=8) with a msb_index-based reference model.
module tb_prio_encoder_rr;
  import prio_enc_pkg::*;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec = '0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] out_onehot;
  logic             out_none;

  int n_checks = 0;
  int n_errors = 0;
  int ptr_m    = WIDTH;

  always #5 clk = ~clk;

  prio_encoder_rr #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_none   (out_none)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: predicts the winner and advances its own pointer copy.
  function automatic int model_step(input logic mode, input logic [7:0] vec);
    logic [31:0] masked;
    int w;
    masked = {24'd0, vec} & ((32'd1 << ptr_m) - 32'd1);
    if (mode && msb_index(masked) >= 0) w = msb_index(masked);
    else                                w = msb_index({24'd0, vec});
    if (mode && w >= 0) ptr_m = w;
    return w;
  endfunction

  task automatic do_txn(input logic mode, input logic [7:0] vec, input int exp_idx);
    int m;
    logic       exp_none;
    logic [7:0] exp_oh;
    @(negedge clk);
    in_valid  = 1'b1;
    in_vec    = vec;
    in_mode   = mode;
    out_ready = 1'b1;
    #1 chk("in_ready", 32'(in_ready), 32'd1);
    m        = model_step(mode, vec);
    exp_none = (vec == 8'h00);
    exp_oh   = exp_none ? 8'h00 : (8'd1 << exp_idx);
    @(posedge clk);
    #1;
    chk("out_valid",  32'(out_valid),  32'd1);
    chk("out_idx",    32'(out_idx),    32'(exp_idx));
    chk("out_onehot", 32'(out_onehot), 32'(exp_oh));
    chk("out_none",   32'(out_none),   32'(exp_none));
    chk("sb_idx",     32'(out_idx),    (m < 0) ? 32'd0 : 32'(m));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1 chk("rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ptr_m = WIDTH;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_idx",    32'(out_idx),    32'd0);
    chk("rst_out_onehot", 32'(out_onehot), 32'd0);
    chk("rst_out_none",   32'(out_none),   32'd0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: fixed priority
    do_txn(1'b0, 8'b0010_0110, 5);
    idle();
    @(posedge clk); #1 chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_idx_hold", 32'(out_idx), 32'd5);

    // 2: round-robin over all-ones, wrapping back to 7
    do_txn(1'b1, 8'hFF, 7); do_txn(1'b1, 8'hFF, 6); do_txn(1'b1, 8'hFF, 5);
    do_txn(1'b1, 8'hFF, 4); do_txn(1'b1, 8'hFF, 3); do_txn(1'b1, 8'hFF, 2);
    do_txn(1'b1, 8'hFF, 1); do_txn(1'b1, 8'hFF, 0); do_txn(1'b1, 8'hFF, 7);
    idle();

    // 3: two-bit alternation; fixed mode must not move the pointer (ptr stays 0 -> MSB)
    do_reset();
    do_txn(1'b1, 8'b1000_0001, 7); do_txn(1'b1, 8'b1000_0001, 0);
    do_txn(1'b1, 8'b1000_0001, 7); do_txn(1'b1, 8'b1000_0001, 0);
    do_txn(1'b0, 8'b1000_0001, 7);
    do_txn(1'b1, 8'b1000_0001, 7);
    do_reset();
    do_txn(1'b1, 8'b0010_0110, 5); do_txn(1'b1, 8'b0010_0110, 2);
    do_txn(1'b1, 8'b0010_0110, 1); do_txn(1'b1, 8'b0010_0110, 5);
    idle();

    // 4: zero vectors leave the pointer alone (ptr=5 here)
    do_txn(1'b1, 8'h00, 0);
    do_txn(1'b0, 8'h00, 0);
    do_txn(1'b1, 8'hFF, 4);
    idle();

    // 5: backpressure with a request pending
    do_txn(1'b0, 8'h06, 2);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 8'h81;
    in_mode   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp_valid",  32'(out_valid),  32'd1);
      chk("bp_idx",    32'(out_idx),    32'd2);
      chk("bp_onehot", 32'(out_onehot), 32'h04);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    void'(model_step(1'b0, 8'h81));
    @(posedge clk); #1;
    chk("bp_new_valid",  32'(out_valid),  32'd1);
    chk("bp_new_idx",    32'(out_idx),    32'd7);
    chk("bp_new_onehot", 32'(out_onehot), 32'h80);
    idle();

    // 6: asynchronous reset drops a held result mid-cycle
    do_reset();
    do_txn(1'b1, 8'hFF, 7);
    do_txn(1'b1, 8'hFF, 6);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_idx", 32'(out_idx), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ptr_m = WIDTH;
    do_txn(1'b1, 8'hFF, 7);
    idle();
    @(posedge clk); #1 chk("end_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
